// File: rtl/updown_rate_ctrl_if.sv
// Button-in / rate-out bundle between the debouncer stage and the rate controller.
interface updown_rate_ctrl_if #(
  parameter int unsigned W_LVL = 3
);
  logic             btn_up;
  logic             btn_dn;
  logic [W_LVL-1:0] level;
  logic             led;
  logic             step_up;
  logic             step_dn;
  logic             sat;

  modport master (
    output btn_up, btn_dn,
    input  level, led, step_up, step_dn, sat
  );

  modport slave (
    input  btn_up, btn_dn,
    output level, led, step_up, step_dn, sat
  );
endinterface

// File: rtl/updown_rate_ctrl.sv
// Saturating up/down blink-rate level with single-step on press, auto-repeat on hold,
// and an LED blinker whose half-period shrinks as the level rises.
module updown_rate_ctrl #(
  parameter int unsigned W_LVL      = 3,
  parameter int unsigned LVL_INIT   = 4,
  parameter int unsigned HOLD_CYC   = 12_500_000,
  parameter int unsigned REPEAT_CYC = 2_500_000,
  parameter int unsigned BASE_CYC   = 1_562_500,
  parameter int unsigned W_CNT      = 26
) (
  input  logic                clk,
  input  logic                rst,
  updown_rate_ctrl_if.slave   bus
);
  localparam int unsigned      LVL_MAX   = (1 << W_LVL) - 1;
  localparam logic [W_CNT-1:0] HOLD_LAST = W_CNT'(HOLD_CYC - 1);
  localparam logic [W_CNT-1:0] RPT_LAST  = W_CNT'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    RPT_UP,
    RPT_DN
  } state_t;

  state_t           state;
  logic [W_CNT-1:0] timer;
  logic [W_CNT-1:0] blink_cnt;
  logic [W_CNT-1:0] half;
  logic [W_LVL-1:0] level;
  logic             led;
  logic             step_up;
  logic             step_dn;
  logic             sat;
  logic             up_prev;
  logic             dn_prev;
  logic             press_up;
  logic             press_dn;
  logic             req_up;
  logic             req_dn;
  logic             at_max;
  logic             at_min;
  logic             lvl_inc;
  logic             lvl_dec;

  assign press_up = bus.btn_up & ~up_prev;
  assign press_dn = bus.btn_dn & ~dn_prev;
  assign at_max   = (level == W_LVL'(LVL_MAX));
  assign at_min   = (level == '0);
  assign lvl_inc  = req_up & ~at_max;
  assign lvl_dec  = req_dn & ~at_min;
  assign half     = W_CNT'(BASE_CYC) * (W_CNT'(LVL_MAX + 1) - W_CNT'(level));

  // Step requests; the owning button must still be held for a timed step.
  always_comb begin
    req_up = 1'b0;
    req_dn = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_up && !press_dn)      req_up = 1'b1;
        else if (press_dn && !press_up) req_dn = 1'b1;
      end
      HOLD_UP: req_up = bus.btn_up && (timer == HOLD_LAST);
      HOLD_DN: req_dn = bus.btn_dn && (timer == HOLD_LAST);
      RPT_UP:  req_up = bus.btn_up && (timer == RPT_LAST);
      RPT_DN:  req_dn = bus.btn_dn && (timer == RPT_LAST);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      blink_cnt <= '0;
      level     <= W_LVL'(LVL_INIT);
      led       <= 1'b0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      sat       <= 1'b0;
      up_prev   <= bus.btn_up;
      dn_prev   <= bus.btn_dn;
    end else begin
      up_prev <= bus.btn_up;
      dn_prev <= bus.btn_dn;
      step_up <= lvl_inc;
      step_dn <= lvl_dec;
      sat     <= (req_up & at_max) | (req_dn & at_min);

      if (lvl_inc)      level <= level + W_LVL'(1);
      else if (lvl_dec) level <= level - W_LVL'(1);

      unique case (state)
        IDLE: begin
          timer <= '0;
          if (req_up)      state <= HOLD_UP;
          else if (req_dn) state <= HOLD_DN;
        end
        HOLD_UP, RPT_UP: begin
          if (!bus.btn_up) begin
            state <= IDLE;
            timer <= '0;
          end else if (req_up) begin
            state <= RPT_UP;
            timer <= '0;
          end else begin
            timer <= timer + W_CNT'(1);
          end
        end
        HOLD_DN, RPT_DN: begin
          if (!bus.btn_dn) begin
            state <= IDLE;
            timer <= '0;
          end else if (req_dn) begin
            state <= RPT_DN;
            timer <= '0;
          end else begin
            timer <= timer + W_CNT'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase

      // A real level change restarts the period; a saturated request does not.
      if (lvl_inc || lvl_dec) begin
        blink_cnt <= '0;
      end else if (blink_cnt == half - W_CNT'(1)) begin
        blink_cnt <= '0;
        led       <= ~led;
      end else begin
        blink_cnt <= blink_cnt + W_CNT'(1);
      end
    end
  end

  assign bus.level   = level;
  assign bus.led     = led;
  assign bus.step_up = step_up;
  assign bus.step_dn = step_dn;
  assign bus.sat     = sat;
endmodule

// File: tb/tb_updown_rate_ctrl.sv
// Directed bench for updown_rate_ctrl with small timing parameters (HOLD 8, REPEAT 4, BASE 2).
module tb_updown_rate_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  updown_rate_ctrl_if #(.W_LVL(3)) bus ();

  updown_rate_ctrl #(
    .W_LVL     (3),
    .LVL_INIT  (4),
    .HOLD_CYC  (8),
    .REPEAT_CYC(4),
    .BASE_CYC  (2),
    .W_CNT     (26)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pulses packed as {step_up, step_dn, sat}
  task automatic chk_pulses(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.step_up, bus.step_dn, bus.sat}, {29'd0, exp});
  endtask

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;

    // 1: reset state and level-4 blink (toggle every 8 cycles)
    rst = 1'b1;
    tick();
    tick();
    chk("rst_level", 32'(bus.level), 32'd4);
    chk("rst_led", 32'(bus.led), 32'd0);
    chk_pulses("rst_pulses", 3'b000);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7)  chk("t1_led7", 32'(bus.led), 32'd0);
      if (i == 8)  chk("t1_led8", 32'(bus.led), 32'd1);
      if (i == 15) chk("t1_led15", 32'(bus.led), 32'd1);
      if (i == 16) chk("t1_led16", 32'(bus.led), 32'd0);
      chk_pulses("t1_pulses", 3'b000);
    end

    // 2: short press -> single step, blink restarts with half 6
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 3) bus.btn_up = 1'b0;
      chk_pulses("t2_pulses", (i == 1) ? 3'b100 : 3'b000);
      chk("t2_level", 32'(bus.level), 32'd5);
      if (i == 6) chk("t2_led6", 32'(bus.led), 32'd0);
      if (i == 7) chk("t2_led7", 32'(bus.led), 32'd1);
    end

    // 3: hold up from level 4 -> steps at 1,9,13, sat at 17, led every 2 cycles at level 7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk_pulses("t3_pulses", {(i == 1 || i == 9 || i == 13), 1'b0, (i == 17)});
      chk("t3_level", 32'(bus.level), (i < 9) ? 32'd5 : (i < 13) ? 32'd6 : 32'd7);
      if (i >= 13) chk("t3_led", 32'(bus.led), ((((i - 13) / 2) % 2) == 0) ? 32'd1 : 32'd0);
    end
    bus.btn_up = 1'b0;
    tick();
    chk_pulses("t3_release", 3'b000);
    chk("t3_level_hold", 32'(bus.level), 32'd7);

    // 4: walk down to level 1 from reset, then hold down: step to 0, saturate
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      bus.btn_dn = 1'b1;
      tick();
      chk_pulses("t4_walk", 3'b010);
      bus.btn_dn = 1'b0;
      tick();
    end
    chk("t4_level1", 32'(bus.level), 32'd1);
    bus.btn_dn = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk_pulses("t4_pulses", {1'b0, (i == 1), (i == 9 || i == 13 || i == 17)});
      chk("t4_level", 32'(bus.level), 32'd0);
      if (i == 16) chk("t4_led16", 32'(bus.led), 32'd0);
      if (i == 17) chk("t4_led17", 32'(bus.led), 32'd1);
    end
    bus.btn_dn = 1'b0;
    tick();

    // 5: simultaneous presses ignored; down ignored while up owns the FSM
    bus.btn_up = 1'b1;
    bus.btn_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_pulses("t5_both", 3'b000);
    end
    chk("t5_both_level", 32'(bus.level), 32'd0);
    bus.btn_up = 1'b0;
    bus.btn_dn = 1'b0;
    tick();
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 2) bus.btn_dn = 1'b1;
      chk_pulses("t5_own", {(i == 1 || i == 9 || i == 13), 2'b00});
      chk("t5_level", 32'(bus.level), (i < 9) ? 32'd1 : (i < 13) ? 32'd2 : 32'd3);
    end
    bus.btn_up = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_pulses("t5_dn_held", 3'b000);
    end
    chk("t5_final_level", 32'(bus.level), 32'd3);
    bus.btn_dn = 1'b0;
    tick();

    // 6: button held through reset is not a press; reset during auto-repeat
    bus.btn_up = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("t6_rst_level", 32'(bus.level), 32'd4);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_pulses("t6_held_pulses", 3'b000);
      chk("t6_held_level", 32'(bus.level), 32'd4);
    end
    bus.btn_up = 1'b0;
    tick();
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("t6_rpt_level", 32'(bus.level), (i < 9) ? 32'd5 : 32'd6);
    end
    rst = 1'b1;
    tick();
    chk("t6_mid_level", 32'(bus.level), 32'd4);
    chk("t6_mid_led", 32'(bus.led), 32'd0);
    chk_pulses("t6_mid_pulses", 3'b000);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_pulses("t6_after_pulses", 3'b000);
      chk("t6_after_level", 32'(bus.level), 32'd4);
    end
    bus.btn_up = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
